perceptron_seq: RTL and testbench

Sequencer for the perceptron neuron datapath: accumulates a bias plus N_IN gated 2-bit signed weights through one shared 4-bit + 2-bit signed adder, one term per clock. It produces a 4-bit signed weighted sum and a threshold (fire) bit. It sits between the input/weight registers and the classifier output logic. A start/busy/done handshake lets a higher-level controller run one evaluation at a time.

---
 rtl/perceptron_pkg.sv | 19 +
 rtl/perceptron_sat_add.sv | 29 ++
 rtl/perceptron_seq.sv | 115 +++++++++++
 tb/tb_perceptron_seq.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/perceptron_pkg.sv
// Shared types and constants for the perceptron sequencer.
// Build option: define PERCEPTRON_SAT_EN for saturating accumulation
// (default build wraps modulo 16).
package perceptron_pkg;

  localparam int ACC_W = 4;
  localparam int W_W   = 2;

  localparam logic [ACC_W-1:0] SAT_MAX = 4'b0111;
  localparam logic [ACC_W-1:0] SAT_MIN = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/perceptron_sat_add.sv
// Combinational 4-bit signed accumulator plus 2-bit signed term.
// Build option: PERCEPTRON_SAT_EN clamps each result to [-8, +7];
// without it the result wraps modulo 16.
module perceptron_sat_add
  import perceptron_pkg::*;
(
  input  logic [ACC_W-1:0] a,
  input  logic [W_W-1:0]   b,
  output logic [ACC_W-1:0] s
);

  logic [ACC_W:0] ext_sum;

  // One guard bit catches overflow: it differs from the result MSB exactly
  // when the true sum left the 4-bit range.
  always_comb begin
    ext_sum = {a[ACC_W-1], a} + {{(ACC_W+1-W_W){b[W_W-1]}}, b};
`ifdef PERCEPTRON_SAT_EN
    if (ext_sum[ACC_W] != ext_sum[ACC_W-1]) begin
      s = ext_sum[ACC_W] ? SAT_MIN : SAT_MAX;
    end else begin
      s = ext_sum[ACC_W-1:0];
    end
`else
    s = ext_sum[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/perceptron_seq.sv
// Perceptron neuron sequencer: bias plus N_IN gated 2-bit weights,
// accumulated one term per clock through a single shared adder.
// Build option: PERCEPTRON_SAT_EN selects saturating adds (see perceptron_sat_add).
module perceptron_seq
  import perceptron_pkg::*;
#(
  parameter int N_IN = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N_IN-1:0]       x,
  input  logic [W_W*N_IN-1:0]   w,
  input  logic [ACC_W-1:0]      bias,
  output logic                  busy,
  output logic                  done,
  output logic [ACC_W-1:0]      sum,
  output logic                  y
);

  localparam int IDX_W = $clog2(N_IN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IN - 1);

  state_t                      state_q, state_d;
  logic [ACC_W-1:0]            acc_q, acc_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [ACC_W-1:0]            sum_q, sum_d;
  logic                        y_q, y_d;
  logic [N_IN-1:0]             x_q, x_d;
  logic [N_IN-1:0][W_W-1:0]    w_q, w_d;
  logic [ACC_W-1:0]            bias_q, bias_d;

  logic [W_W-1:0]              term;
  logic [ACC_W-1:0]            add_s;

  // Gated weight for the current index; a cleared input contributes zero.
  assign term = x_q[idx_q] ? w_q[idx_q] : '0;

  perceptron_sat_add u_add (
    .a (acc_q),
    .b (term),
    .s (add_s)
  );

  // Next-state, datapath and result-capture logic.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    y_d     = y_q;
    x_d     = x_q;
    w_d     = w_q;
    bias_d  = bias_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = x;
          w_d     = w;
          bias_d  = bias;
          state_d = LOAD;
        end
      end
      LOAD: begin
        acc_d   = bias_q;
        idx_d   = '0;
        state_d = ACC;
      end
      ACC: begin
        acc_d = add_s;
        idx_d = idx_q + 1'b1;
        // Capture the result on the last term so sum/y are already
        // valid in the DONE cycle alongside the done pulse.
        if (idx_q == IDX_LAST) begin
          sum_d   = add_s;
          y_d     = ~add_s[ACC_W-1];
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
      y_q     <= 1'b0;
      x_q     <= '0;
      w_q     <= '0;
      bias_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      y_q     <= y_d;
      x_q     <= x_d;
      w_q     <= w_d;
      bias_q  <= bias_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign y    = y_q;

endmodule

// File: tb/tb_perceptron_seq.sv
// Scoreboard bench for perceptron_seq with directed, hand-computed vectors.
// Expected results follow PERCEPTRON_SAT_EN when the overflow vectors run.
module tb_perceptron_seq;

  localparam int N_IN = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [N_IN-1:0]     x;
  logic [2*N_IN-1:0]   w;
  logic [3:0]          bias;
  logic                busy;
  logic                done;
  logic [3:0]          sum;
  logic                y;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [3:0] sum;
    logic       y;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  perceptron_seq #(.N_IN(N_IN)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x     (x),
    .w     (w),
    .bias  (bias),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .y     (y)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("done_sum", 32'(sum), 32'(mon_e.sum));
        chk("done_y", 32'(y), 32'(mon_e.y));
        chk("done_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  // Issue one evaluation; optionally re-pulse start and scramble the
  // inputs while the run is in flight.
  task automatic run(input logic [3:0] b, input logic [3:0] xv, input logic [7:0] wv,
                     input logic [3:0] es, input logic ey, input bit disturb);
    int   n;
    exp_t e;
    @(negedge clk);
    bias  = b;
    x     = xv;
    w     = wv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.sum = es;
    e.y   = ey;
    e.cyc = cyc + 5;  // LOAD now, four ACC cycles, then DONE
    sb.push_back(e);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (disturb) begin
        if (i == 1) begin
          start = 1'b1;
          x     = ~xv;
          w     = ~wv;
          bias  = ~b;
        end else if (i == 2) begin
          start = 1'b0;
        end
      end
      if (busy !== 1'b1) break;
      n++;
    end
    chk("busy_cycles", 32'(n), 32'd6);
    chk("pending", 32'(sb.size()), 32'd0);
    sb.delete();
    repeat (disturb ? 10 : 3) @(negedge clk);
    chk("sum_hold", 32'(sum), 32'(es));
    chk("y_hold", 32'(y), 32'(ey));
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    x     = '0;
    w     = '0;
    bias  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Plain sum: 0 + 1+1+1+1 = 4
    run(4'b0000, 4'b1111, 8'b01_01_01_01, 4'b0100, 1'b1, 1'b0);
    // Gating, mixed signs: w0=+1, w2=-1 active -> 0
    run(4'b0000, 4'b0101, 8'b01_11_10_01, 4'b0000, 1'b1, 1'b0);
    // Only top input active: -8 + 1 = -7
    run(4'b1000, 4'b1000, 8'b01_00_00_00, 4'b1001, 1'b0, 1'b0);
`ifdef PERCEPTRON_SAT_EN
    run(4'b0110, 4'b1111, 8'b01_01_01_01, 4'b0111, 1'b1, 1'b0);
    run(4'b1001, 4'b1111, 8'b11_11_11_11, 4'b1000, 1'b0, 1'b0);
`else
    run(4'b0110, 4'b1111, 8'b01_01_01_01, 4'b1010, 1'b0, 1'b0);
    run(4'b1001, 4'b1111, 8'b11_11_11_11, 4'b0101, 1'b1, 1'b0);
`endif
    // Handshake robustness: restart attempt and input changes mid-run
    run(4'b0000, 4'b1111, 8'b01_01_01_01, 4'b0100, 1'b1, 1'b1);

    // Reset during the second ACC cycle
    @(negedge clk);
    bias  = 4'b0011;
    x     = 4'b1111;
    w     = 8'b01_01_01_01;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);  // LOAD
    @(negedge clk);  // ACC, first term
    @(negedge clk);  // ACC, second term
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_y", 32'(y), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("midrst_quiet", 32'(busy), 32'd0);

    // Normal run after the aborted one
    run(4'b0001, 4'b0011, 8'b00_00_11_01, 4'b0001, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
